poly_note_player: RTL and testbench

//  Polyphonic square-wave tone generator: up to NUM_CH keys sound at once from a fixed note

---
 rtl/poly_note_player.sv | 144 ++++++++++++++
 tb/tb_poly_note_player.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/poly_note_player.sv
// Polyphonic square-wave tone generator: keys are synchronised, assigned to free voices
// with per-voice half-period dividers, and mixed into a 1-bit sigma-delta speaker stream.
module poly_note_player #(
  parameter int CLK_HZ   = 50000000,
  parameter int NUM_KEYS = 8,
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 17
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] keys,
  input  logic [1:0]          octave,
  output logic [NUM_CH-1:0]   voice_active,
  output logic [NUM_CH-1:0]   voice_wave,
  output logic                busy,
  output logic                speaker
);

  localparam int AW = $clog2(2 * NUM_CH);

  // Half-period divisors for C4..C5 at octave 0, folded to constants at elaboration.
  localparam int BASE [8] = '{CLK_HZ / 524, CLK_HZ / 588, CLK_HZ / 660, CLK_HZ / 698,
                              CLK_HZ / 784, CLK_HZ / 880, CLK_HZ / 988, CLK_HZ / 1046};

  logic [NUM_KEYS-1:0] keysMeta;
  logic [NUM_KEYS-1:0] ks;
  logic [7:0]          ksPad;

  logic [2:0]       voiceKey [NUM_CH];
  logic [CNT_W-1:0] voiceDiv [NUM_CH];
  logic [CNT_W-1:0] voiceCnt [NUM_CH];

  logic [7:0]        held;
  logic              candValid;
  logic [2:0]        candKey;
  logic              freeValid;
  logic [2:0]        freeIdx;
  logic              allocNow;
  logic [CNT_W-1:0]  allocDiv;
  logic [NUM_CH-1:0] allocVec;
  logic [NUM_CH-1:0] releaseVec;
  logic [NUM_CH-1:0] nextActive;

  logic [AW-1:0] acc;
  logic [AW:0]   mixSum;

  assign ksPad = 8'(ks);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keysMeta <= '0;
      ks       <= '0;
    end else begin
      keysMeta <= keys;
      ks       <= keysMeta;
    end
  end

  // A releasing voice still counts as active here, so it can only be reused next clock.
  always_comb begin
    held = '0;
    for (int v = 0; v < NUM_CH; v++) begin
      if (voice_active[v]) held[voiceKey[v]] = 1'b1;
    end
    candValid = 1'b0;
    candKey   = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (ksPad[i] && !held[i]) begin
        candValid = 1'b1;
        candKey   = 3'(i);
      end
    end
    freeValid = 1'b0;
    freeIdx   = '0;
    for (int v = NUM_CH - 1; v >= 0; v--) begin
      if (!voice_active[v]) begin
        freeValid = 1'b1;
        freeIdx   = 3'(v);
      end
    end
    allocNow = candValid && freeValid;
    allocDiv = CNT_W'(BASE[candKey]) >> octave;
    if (allocDiv < CNT_W'(2)) allocDiv = CNT_W'(2);
    allocVec   = '0;
    releaseVec = '0;
    for (int v = 0; v < NUM_CH; v++) begin
      if (allocNow && (int'(freeIdx) == v)) allocVec[v] = 1'b1;
      releaseVec[v] = voice_active[v] && !ksPad[voiceKey[v]];
    end
    nextActive = (voice_active & ~releaseVec) | allocVec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      voice_active <= '0;
      voice_wave   <= '0;
      busy         <= 1'b0;
      for (int v = 0; v < NUM_CH; v++) begin
        voiceKey[v] <= '0;
        voiceDiv[v] <= '0;
        voiceCnt[v] <= '0;
      end
    end else begin
      busy <= &nextActive;
      for (int v = 0; v < NUM_CH; v++) begin
        if (allocVec[v]) begin
          voice_active[v] <= 1'b1;
          voiceKey[v]     <= candKey;
          voiceDiv[v]     <= allocDiv;
          voiceCnt[v]     <= allocDiv - CNT_W'(1);
          voice_wave[v]   <= 1'b0;
        end else if (releaseVec[v]) begin
          voice_active[v] <= 1'b0;
          voice_wave[v]   <= 1'b0;
          voiceCnt[v]     <= '0;
        end else if (voice_active[v]) begin
          if (voiceCnt[v] == '0) begin
            voiceCnt[v]   <= voiceDiv[v] - CNT_W'(1);
            voice_wave[v] <= ~voice_wave[v];
          end else begin
            voiceCnt[v] <= voiceCnt[v] - CNT_W'(1);
          end
        end
      end
    end
  end

  assign mixSum = (AW + 1)'(acc) + (AW + 1)'($countones(voice_wave));

  // First-order sigma-delta: emit a 1 each time the running sum crosses NUM_CH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      speaker <= 1'b0;
    end else if (mixSum >= (AW + 1)'(NUM_CH)) begin
      acc     <= AW'(mixSum - (AW + 1)'(NUM_CH));
      speaker <= 1'b1;
    end else begin
      acc     <= AW'(mixSum);
      speaker <= 1'b0;
    end
  end

endmodule

// File: tb/tb_poly_note_player.sv
// Directed bench for poly_note_player: two voices at CLK_HZ=88000, plus a CLK_HZ=8 instance
// that exercises the minimum-divisor clamp.
module tb_poly_note_player;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] keys;
  logic [1:0] octave;
  logic [1:0] voice_active, voice_wave;
  logic       busy, speaker;
  logic [1:0] smallActive, smallWave;
  logic       smallBusy, smallSpeaker;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  poly_note_player #(.CLK_HZ(88000), .NUM_KEYS(8), .NUM_CH(2), .CNT_W(17)) dut (
    .clk(clk), .rst_n(rst_n), .keys(keys), .octave(octave),
    .voice_active(voice_active), .voice_wave(voice_wave), .busy(busy), .speaker(speaker)
  );

  poly_note_player #(.CLK_HZ(8), .NUM_KEYS(8), .NUM_CH(2), .CNT_W(17)) dutSmall (
    .clk(clk), .rst_n(rst_n), .keys(keys), .octave(octave),
    .voice_active(smallActive), .voice_wave(smallWave), .busy(smallBusy), .speaker(smallSpeaker)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; keys = '0; octave = '0;
    tick(2);
    total++; if (voice_active !== 2'b00) begin bad++; $display("[TB] FAIL reset_active got=%b want=00", voice_active); end
    total++; if (voice_wave !== 2'b00) begin bad++; $display("[TB] FAIL reset_wave got=%b want=00", voice_wave); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    total++; if (speaker !== 1'b0) begin bad++; $display("[TB] FAIL reset_speaker got=%b want=0", speaker); end
    rst_n = 1'b1;
  endtask

  task automatic test_single_note;
    int ones;
    keys = 8'h20; octave = 2'd0;
    tick(2);
    total++; if (voice_active !== 2'b00) begin bad++; $display("[TB] FAIL sync_delay got=%b want=00", voice_active); end
    tick(1);
    total++; if (voice_active !== 2'b01) begin bad++; $display("[TB] FAIL alloc_latency got=%b want=01", voice_active); end
    tick(99);
    total++; if (voice_wave[0] !== 1'b0) begin bad++; $display("[TB] FAIL a4_early got=%b want=0", voice_wave[0]); end
    tick(1);
    total++; if (voice_wave[0] !== 1'b1) begin bad++; $display("[TB] FAIL a4_toggle got=%b want=1", voice_wave[0]); end
    ones = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      ones += int'(speaker);
    end
    total++; if (ones !== 50) begin bad++; $display("[TB] FAIL one_voice_duty got=%0d want=50", ones); end
    total++; if (voice_wave[0] !== 1'b0) begin bad++; $display("[TB] FAIL a4_second_toggle got=%b want=0", voice_wave[0]); end
    keys = 8'h00;
    tick(3);
    total++; if (voice_active !== 2'b00 || voice_wave !== 2'b00) begin bad++; $display("[TB] FAIL release got=%b/%b want=00/00", voice_active, voice_wave); end
    tick(2);
  endtask

  task automatic test_octave;
    octave = 2'd1; keys = 8'h20;
    tick(3);
    total++; if (voice_active !== 2'b01) begin bad++; $display("[TB] FAIL oct1_alloc got=%b want=01", voice_active); end
    tick(49);
    total++; if (voice_wave[0] !== 1'b0) begin bad++; $display("[TB] FAIL oct1_early got=%b want=0", voice_wave[0]); end
    tick(1);
    total++; if (voice_wave[0] !== 1'b1) begin bad++; $display("[TB] FAIL oct1_toggle got=%b want=1", voice_wave[0]); end
    keys = 8'h00;
    tick(3);
    total++; if (voice_active !== 2'b00) begin bad++; $display("[TB] FAIL oct1_release got=%b want=00", voice_active); end
    tick(2);
    keys = 8'h01; octave = 2'd0;
    tick(3);
    total++; if (voice_active !== 2'b01) begin bad++; $display("[TB] FAIL c4_alloc got=%b want=01", voice_active); end
    octave = 2'd3;
    tick(166);
    total++; if (voice_wave[0] !== 1'b0) begin bad++; $display("[TB] FAIL c4_early got=%b want=0", voice_wave[0]); end
    tick(1);
    total++; if (voice_wave[0] !== 1'b1) begin bad++; $display("[TB] FAIL c4_toggle got=%b want=1", voice_wave[0]); end
    keys = 8'h00; octave = 2'd0;
    tick(5);
  endtask

  // Leaves voice0 on key2 (toggled high at edge 289) and voice1 on key1 (high since edge 152).
  task automatic test_alloc_order;
    keys = 8'h07;
    tick(2);
    total++; if (voice_active !== 2'b00) begin bad++; $display("[TB] FAIL multi_sync got=%b want=00", voice_active); end
    tick(1);
    total++; if (voice_active !== 2'b01 || busy !== 1'b0) begin bad++; $display("[TB] FAIL multi_first got=%b busy=%b want=01 busy=0", voice_active, busy); end
    tick(1);
    total++; if (voice_active !== 2'b11 || busy !== 1'b1) begin bad++; $display("[TB] FAIL multi_second got=%b busy=%b want=11 busy=1", voice_active, busy); end
    tick(148);
    total++; if (voice_active !== 2'b11 || voice_wave !== 2'b00) begin bad++; $display("[TB] FAIL key2_ignored got=%b wave=%b want=11 wave=00", voice_active, voice_wave); end
    tick(1);
    total++; if (voice_wave !== 2'b10) begin bad++; $display("[TB] FAIL d4_toggle got=%b want=10", voice_wave); end
    keys = 8'h06;
    tick(3);
    total++; if (voice_active !== 2'b10 || busy !== 1'b0) begin bad++; $display("[TB] FAIL key0_free got=%b busy=%b want=10 busy=0", voice_active, busy); end
    tick(1);
    total++; if (voice_active !== 2'b11 || busy !== 1'b1) begin bad++; $display("[TB] FAIL key2_alloc got=%b busy=%b want=11 busy=1", voice_active, busy); end
    tick(132);
    total++; if (voice_wave[0] !== 1'b0) begin bad++; $display("[TB] FAIL e4_early got=%b want=0", voice_wave[0]); end
    tick(1);
    total++; if (voice_wave !== 2'b11) begin bad++; $display("[TB] FAIL e4_toggle got=%b want=11", voice_wave); end
  endtask

  task automatic test_mixer_full;
    int ones;
    ones = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      ones += int'(speaker);
    end
    total++; if (ones !== 10) begin bad++; $display("[TB] FAIL two_voice_duty got=%0d want=10", ones); end
  endtask

  task automatic test_reset_midnote;
    #2 rst_n = 1'b0;
    #1;
    total++; if (voice_active !== 2'b00 || voice_wave !== 2'b00) begin bad++; $display("[TB] FAIL async_reset_voices got=%b/%b want=00/00", voice_active, voice_wave); end
    total++; if (busy !== 1'b0 || speaker !== 1'b0) begin bad++; $display("[TB] FAIL async_reset_outs got=%b/%b want=0/0", busy, speaker); end
    tick(2);
    rst_n = 1'b1;
    tick(2);
    total++; if (voice_active !== 2'b00) begin bad++; $display("[TB] FAIL post_reset_sync got=%b want=00", voice_active); end
    tick(1);
    total++; if (voice_active !== 2'b01) begin bad++; $display("[TB] FAIL post_reset_first got=%b want=01", voice_active); end
    tick(1);
    total++; if (voice_active !== 2'b11 || busy !== 1'b1) begin bad++; $display("[TB] FAIL post_reset_second got=%b busy=%b want=11 busy=1", voice_active, busy); end
  endtask

  task automatic test_clamp;
    logic expW [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    keys = 8'h00; rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1; keys = 8'h01; octave = 2'd3;
    tick(3);
    total++; if (smallActive !== 2'b01 || smallWave !== 2'b00) begin bad++; $display("[TB] FAIL clamp_alloc got=%b/%b want=01/00", smallActive, smallWave); end
    for (int i = 0; i < 6; i++) begin
      tick(1);
      total++; if (smallWave[0] !== expW[i]) begin bad++; $display("[TB] FAIL clamp_wave[%0d] got=%b want=%b", i, smallWave[0], expW[i]); end
    end
  endtask

  initial begin
    test_reset;
    test_single_note;
    test_octave;
    test_alloc_order;
    test_mixer_full;
    test_reset_midnote;
    test_clamp;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
